sram_row_reader: RTL and testbench
==================================

Name: sram_row_reader

Overview:
- Read-side counterpart of the SRAM address generator: fetches one image row of pixels from SRAM starting at a base address and streams them to the row-cache/processing core over a valid/ready interface.
- Owns its own read address sequencing, tolerates a fixed SRAM read latency, and buffers returned data in a small credit-limited FIFO so consumer back-pressure never loses data.

Parameters:
- ADDR_W, 26, SRAM address width
- CNT_W, 13, pixel count / image_width width
- DATA_W, 16, SRAM data / pixel width
- RD_LAT, 2, cycles from sram_rd_en asserted to sram_rdata valid (>=1)
- FIFO_DEPTH, 4, return-data buffer entries (power of 2, >= RD_LAT+1)

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- clear  in  1  synchronous abort: flush and return to IDLE
- start  in  1  begin row fetch (sampled only in IDLE)
- row_base_addr  in  ADDR_W  first SRAM address of row, latched on start
- image_width  in  CNT_W  pixels to read, latched on start
- sram_rd_en  out  1  SRAM read strobe, one read per asserted cycle
- sram_addr  out  ADDR_W  read address, valid when sram_rd_en=1
- sram_rdata  in  DATA_W  read data, valid RD_LAT cycles after its strobe
- pix_data  out  DATA_W  head-of-FIFO pixel
- pix_valid  out  1  pix_data valid
- pix_ready  in  1  consumer accepts; transfer when pix_valid & pix_ready
- busy  out  1  high in any state other than IDLE
- done  out  1  one-cycle pulse after last pixel of row is transferred

Behaviour:
- Reset (rst=1, asynchronous): state=IDLE; sram_rd_en=0, sram_addr=0, pix_data=0, pix_valid=0, busy=0, done=0; counters, FIFO pointers and in-flight pipeline cleared.
- FSM: IDLE -> READ on start (width>0); IDLE -> DONE on start with width=0 (no SRAM reads); READ -> DRAIN when issued count reaches width; DRAIN -> DONE when FIFO empty and no reads in flight; DONE -> IDLE unconditionally (done=1 for that single cycle).
- start outside IDLE ignored; latched base/width unaffected.
- Issue rule: in READ, sram_rd_en=1 iff issued<width and (in_flight + fifo_count) < FIFO_DEPTH. Max one read per cycle.
- Address: sram_addr = base + issued, computed modulo 2^ADDR_W (issued zero-extended; wrap past all-ones to 0 is legal). sram_addr driven to 0 when sram_rd_en=0.
- Latency: start sampled in cycle 0 -> first sram_rd_en in cycle 1 at base; data written into FIFO at end of cycle 1+RD_LAT; pix_valid=1 from cycle 2+RD_LAT. With pix_ready held high, one pixel per cycle sustained.
- In-flight tracking: RD_LAT-deep shift register of strobe bits; returning bit writes sram_rdata into FIFO. Credit rule guarantees FIFO never overflows; no write ever dropped.
- Output: pix_valid = FIFO non-empty; pix_data = FIFO head (registered storage). pix_data/pix_valid must hold stable while pix_valid & !pix_ready. Simultaneous FIFO push and pop in the same cycle allowed at any occupancy including full.
- Pixels delivered strictly in address order; exactly width transfers per row.
- done asserts one cycle after the cycle of the final transfer.
- clear (any state, priority over start): next state IDLE, FIFO emptied, in-flight strobes discarded (their returning data not written), no done pulse, sram_rd_en=0 next cycle. start in same cycle as clear ignored.
- rst mid-row: immediate return to reset values; no residual pixels after release.

Test Plan:
- Basic row: base=0x100, width=5, pix_ready=1 -> reads at 0x100..0x104 in cycles 1..5, pixels in order cycles 4..8 (RD_LAT=2), done pulse cycle 9, busy low cycle 10.
- Back-pressure: width=8, pix_ready=0 for 20 cycles then 1 -> exactly FIFO_DEPTH=4 reads issued then sram_rd_en stalls; pix_data holds first pixel; after release all 8 delivered in order, no duplicates or losses.
- Address wrap: base=0x3FFFFFE, width=4 -> addresses 0x3FFFFFE, 0x3FFFFFF, 0x0000000, 0x0000001.
- Zero width: start with width=0 -> no sram_rd_en, done pulse one cycle after IDLE->DONE, busy high exactly one cycle.
- Abort: clear asserted two cycles after first read of width=10 -> no further reads, pix_valid 0 next cycle, late returning data ignored, no done; fresh start then reads width 3 correctly.
- Reset mid-row and start-while-busy: start pulse during READ ignored (width unchanged); rst asserted mid-DRAIN -> all outputs 0 immediately, same-row restart delivers full row.

Source files
------------

// File: rtl/sram_row_reader.sv
// -----------------------------------------------------------------------------
// sram_row_reader
//   Fetches one image row from SRAM, starting at a latched base address, and
//   streams the pixels to the consumer over a valid/ready handshake. Reads are
//   credit-limited so that every read in flight already has a free slot in the
//   return FIFO. Consumer back-pressure therefore never drops a pixel.
//
// Ports
//   clk, rst          clock (rising edge), asynchronous active-high reset
//   clear             synchronous abort: flush everything and return to IDLE
//   start             begin a row fetch (sampled only in IDLE)
//   row_base_addr     first SRAM address of the row (latched on start)
//   image_width       number of pixels to read (latched on start)
//   sram_rd_en        read strobe, one read per asserted cycle
//   sram_addr         read address (0 when sram_rd_en=0)
//   sram_rdata        read data, valid RD_LAT cycles after its strobe
//   pix_data          head-of-FIFO pixel (0 when the FIFO is empty)
//   pix_valid         pix_data is valid
//   pix_ready         consumer accepts pix_data
//   busy              high in every state except IDLE
//   done              one-cycle pulse, the cycle after the last transfer
// -----------------------------------------------------------------------------
module sram_row_reader #(
  parameter int ADDR_W     = 26,
  parameter int CNT_W      = 13,
  parameter int DATA_W     = 16,
  parameter int RD_LAT     = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              start,
  input  logic [ADDR_W-1:0] row_base_addr,
  input  logic [CNT_W-1:0]  image_width,
  output logic              sram_rd_en,
  output logic [ADDR_W-1:0] sram_addr,
  input  logic [DATA_W-1:0] sram_rdata,
  output logic [DATA_W-1:0] pix_data,
  output logic              pix_valid,
  input  logic              pix_ready,
  output logic              busy,
  output logic              done
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int OCC_W = $clog2(FIFO_DEPTH + RD_LAT + 1);
  localparam logic [PTR_W:0] COUNT_ONE = 1;

  typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

  state_t              state;
  logic [ADDR_W-1:0]   base;
  logic [CNT_W-1:0]    width;
  logic [CNT_W-1:0]    issued;
  logic [RD_LAT-1:0]   in_flight;   // bit i set: a read issued i+1 cycles ago
  logic [DATA_W-1:0]   mem [FIFO_DEPTH];
  logic [PTR_W-1:0]    wr_ptr;
  logic [PTR_W-1:0]    rd_ptr;
  logic [PTR_W:0]      fifo_count;

  logic [OCC_W-1:0]    occupancy;
  logic                issue;
  logic                push;
  logic                pop;
  logic                drained;

  // Everything below is decoded from registered state only, so the SRAM and
  // consumer interfaces carry no combinational path from this block's inputs.
  always_comb begin
    // NOTE: every signal assigned in always_comb gets a default first, so no
    // path through the block can leave it unassigned and infer a latch.
    occupancy = OCC_W'(fifo_count);
    for (int i = 0; i < RD_LAT; i++) begin
      occupancy = occupancy + OCC_W'(in_flight[i]);
    end
  end

  // A read is issued only when its data is guaranteed a FIFO slot on return.
  assign issue      = (state == READ) && (issued < width) &&
                      (occupancy < OCC_W'(FIFO_DEPTH));
  assign push       = in_flight[RD_LAT-1];
  assign pix_valid  = (fifo_count != '0);
  assign pop        = pix_valid && pix_ready;
  assign pix_data   = pix_valid ? mem[rd_ptr] : '0;
  assign sram_rd_en = issue;
  assign sram_addr  = issue ? base + ADDR_W'(issued) : '0;
  assign busy       = (state != IDLE);
  assign done       = (state == DONE);

  // True when the FIFO will be empty next cycle with nothing left in flight,
  // i.e. this cycle carries (or already carried) the final transfer.
  assign drained = (in_flight == '0) &&
                   ((fifo_count == '0) || ((fifo_count == COUNT_ONE) && pop));

  // NOTE: the FIFO storage is deliberately left without a reset; pix_data is
  // masked to zero while the FIFO is empty, so stale contents never escape.
  always_ff @(posedge clk) begin
    if (push && !clear) begin
      mem[wr_ptr] <= sram_rdata;
    end
  end

  // NOTE: all sequential state uses non-blocking assignments so every
  // register samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      base       <= '0;
      width      <= '0;
      issued     <= '0;
      in_flight  <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else if (clear) begin
      // Abort: in-flight strobes are discarded, so their data is never pushed.
      state      <= IDLE;
      issued     <= '0;
      in_flight  <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      in_flight[0] <= issue;
      for (int i = 1; i < RD_LAT; i++) begin
        in_flight[i] <= in_flight[i-1];
      end

      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase

      if (issue) issued <= issued + 1'b1;

      case (state)
        IDLE: begin
          if (start) begin
            base   <= row_base_addr;
            width  <= image_width;
            issued <= '0;
            state  <= (image_width == '0) ? DONE : READ;
          end
        end
        READ: begin
          if (issue && (issued == width - 1'b1)) state <= DRAIN;
        end
        DRAIN: begin
          if (drained) state <= DONE;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_row_reader.sv
module tb_sram_row_reader;

  localparam int ADDR_W = 26;
  localparam int CNT_W  = 13;
  localparam int DATA_W = 16;
  localparam int RD_LAT = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic              clear;
  logic              start;
  logic [ADDR_W-1:0] row_base_addr;
  logic [CNT_W-1:0]  image_width;
  logic              sram_rd_en;
  logic [ADDR_W-1:0] sram_addr;
  logic [DATA_W-1:0] sram_rdata;
  logic [DATA_W-1:0] pix_data;
  logic              pix_valid;
  logic              pix_ready;
  logic              busy;
  logic              done;

  sram_row_reader dut (
    .clk          (clk),
    .rst          (rst),
    .clear        (clear),
    .start        (start),
    .row_base_addr(row_base_addr),
    .image_width  (image_width),
    .sram_rd_en   (sram_rd_en),
    .sram_addr    (sram_addr),
    .sram_rdata   (sram_rdata),
    .pix_data     (pix_data),
    .pix_valid    (pix_valid),
    .pix_ready    (pix_ready),
    .busy         (busy),
    .done         (done)
  );

  always #5 clk = ~clk;

  // SRAM contents as a fixed function of the address.
  function automatic logic [DATA_W-1:0] mem_val(input logic [ADDR_W-1:0] a);
    return a[15:0] ^ 16'h5A00 ^ {6'd0, a[25:16]};
  endfunction

  // SRAM model: data for a strobe in cycle k appears during cycle k+RD_LAT.
  logic              p_v [RD_LAT];
  logic [ADDR_W-1:0] p_a [RD_LAT];
  initial for (int i = 0; i < RD_LAT; i++) begin p_v[i] = 1'b0; p_a[i] = '0; end
  always @(posedge clk) begin
    p_v[0] <= sram_rd_en;
    p_a[0] <= sram_addr;
    for (int i = 1; i < RD_LAT; i++) begin
      p_v[i] <= p_v[i-1];
      p_a[i] <= p_a[i-1];
    end
  end
  assign sram_rdata = p_v[RD_LAT-1] ? mem_val(p_a[RD_LAT-1]) : 16'hDEAD;

  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;
  int t0       = 0;
  int done_n   = 0;
  int done_rel = -1;
  int busy_last = -1;

  logic [DATA_W-1:0] sb [$];       // expected pixels, in order
  logic [ADDR_W-1:0] rd_addr [$];  // observed read addresses
  int                rd_rel [$];   // observed read cycles, relative to start
  int                xfer_rel [$]; // observed transfer cycles

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: logs reads/done/busy, compares every presented pixel with the
  // scoreboard head and pops on each transfer.
  always @(negedge clk) begin
    if (!rst) begin
      if (sram_rd_en) begin
        rd_addr.push_back(sram_addr);
        rd_rel.push_back(cyc - t0);
      end
      if (done) begin
        done_n++;
        done_rel = cyc - t0;
      end
      if (busy) busy_last = cyc - t0;
      if (pix_valid) begin
        if (sb.size() == 0) check("unexpected_pixel", 64'(pix_data), 64'hFFFF_FFFF);
        else check("pix_data", 64'(pix_data), 64'(sb[0]));
        if (pix_ready) begin
          if (sb.size() != 0) void'(sb.pop_front());
          xfer_rel.push_back(cyc - t0);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    rd_addr.delete();
    rd_rel.delete();
    xfer_rel.delete();
  endtask

  // Issues start in the current cycle (cycle 0); returns in cycle 1.
  task automatic start_row(input logic [ADDR_W-1:0] b, input int w, input logic rdy, input bit expect_pix);
    logic [ADDR_W-1:0] a;
    clear_logs();
    row_base_addr = b;
    image_width   = CNT_W'(w);
    pix_ready     = rdy;
    start         = 1'b1;
    t0            = cyc;
    if (expect_pix) begin
      for (int i = 0; i < w; i++) begin
        a = b + ADDR_W'(i);
        sb.push_back(mem_val(a));
      end
    end
    step();
    start = 1'b0;
  endtask

  task automatic wait_done(input int limit);
    int d0 = done_n;
    int n  = 0;
    while (done_n == d0 && n < limit) begin
      step();
      n++;
    end
    check("done_seen", 64'(done_n != d0), 64'd1);
  endtask

  task automatic check_reads(input string name, input logic [ADDR_W-1:0] b, input int w);
    logic [ADDR_W-1:0] a;
    check({name, "_rd_count"}, 64'(rd_addr.size()), 64'(w));
    for (int i = 0; i < w && i < rd_addr.size(); i++) begin
      a = b + ADDR_W'(i);
      check({name, "_rd_addr"}, 64'(rd_addr[i]), 64'(a));
    end
  endtask

  task automatic check_outputs_zero(input string name);
    check({name, "_rd_en"},  64'(sram_rd_en), 64'd0);
    check({name, "_addr"},   64'(sram_addr),  64'd0);
    check({name, "_pdata"},  64'(pix_data),   64'd0);
    check({name, "_pvalid"}, 64'(pix_valid),  64'd0);
    check({name, "_busy"},   64'(busy),       64'd0);
    check({name, "_done"},   64'(done),       64'd0);
  endtask

  initial begin
    int d0;
    rst = 1'b1; clear = 1'b0; start = 1'b0; pix_ready = 1'b0;
    row_base_addr = '0; image_width = '0;
    #3;
    check_outputs_zero("reset");
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    step();

    // Basic row: reads cycles 1..5, pixels cycles 4..8, done 9, busy low 10.
    start_row(26'h100, 5, 1'b1, 1'b1);
    wait_done(40);
    step(); step();
    check_reads("basic", 26'h100, 5);
    for (int i = 0; i < rd_rel.size(); i++) check("basic_rd_cycle", 64'(rd_rel[i]), 64'(i + 1));
    check("basic_xfer_count", 64'(xfer_rel.size()), 64'd5);
    for (int i = 0; i < xfer_rel.size(); i++) check("basic_xfer_cycle", 64'(xfer_rel[i]), 64'(i + 4));
    check("basic_done_cycle", 64'(done_rel), 64'd9);
    check("basic_busy_last", 64'(busy_last), 64'd9);

    // Back-pressure: only FIFO_DEPTH reads while the consumer stalls.
    start_row(26'h200, 8, 1'b0, 1'b1);
    repeat (19) step();
    check("bp_stalled_reads", 64'(rd_addr.size()), 64'd4);
    check("bp_valid_held", 64'(pix_valid), 64'd1);
    check("bp_head_held", 64'(pix_data), 64'(mem_val(26'h200)));
    pix_ready = 1'b1;
    wait_done(60);
    check_reads("bp", 26'h200, 8);
    check("bp_xfer_count", 64'(xfer_rel.size()), 64'd8);
    check("bp_sb_empty", 64'(sb.size()), 64'd0);

    // Address wrap past all-ones.
    start_row(26'h3FF_FFFE, 4, 1'b1, 1'b1);
    wait_done(40);
    check_reads("wrap", 26'h3FF_FFFE, 4);
    check("wrap_xfer_count", 64'(xfer_rel.size()), 64'd4);

    // Zero width: straight to DONE, no reads, busy for exactly one cycle.
    step();
    start_row(26'h123, 0, 1'b1, 1'b1);
    check("zw_busy_c1", 64'(busy), 64'd1);
    check("zw_done_c1", 64'(done), 64'd1);
    step();
    check("zw_busy_c2", 64'(busy), 64'd0);
    check("zw_done_c2", 64'(done), 64'd0);
    step();
    check("zw_no_reads", 64'(rd_addr.size()), 64'd0);

    // Abort two cycles after the first read; start in the same cycle ignored.
    d0 = done_n;
    start_row(26'h300, 10, 1'b1, 1'b0);
    step();
    step();
    clear = 1'b1; start = 1'b1; image_width = 13'd2;
    step();
    clear = 1'b0; start = 1'b0;
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_pvalid", 64'(pix_valid), 64'd0);
    check("abort_rd_en", 64'(sram_rd_en), 64'd0);
    repeat (6) step();
    check_reads("abort", 26'h300, 3);
    check("abort_no_done", 64'(done_n), 64'(d0));
    check("abort_no_xfer", 64'(xfer_rel.size()), 64'd0);
    start_row(26'h400, 3, 1'b1, 1'b1);
    wait_done(40);
    check_reads("post_abort", 26'h400, 3);
    check("post_abort_xfer", 64'(xfer_rel.size()), 64'd3);

    // Start while busy is ignored.
    step();
    start_row(26'h500, 6, 1'b1, 1'b1);
    row_base_addr = 26'h900; image_width = 13'd2; start = 1'b1;
    step();
    start = 1'b0;
    wait_done(40);
    check_reads("busy_start", 26'h500, 6);
    check("busy_start_xfer", 64'(xfer_rel.size()), 64'd6);

    // Reset in DRAIN, then restart the same row.
    step();
    start_row(26'h600, 6, 1'b1, 1'b1);
    repeat (6) step();
    check("drain_busy", 64'(busy), 64'd1);
    rst = 1'b1;
    #1;
    check_outputs_zero("midrst");
    sb.delete();
    step();
    rst = 1'b0;
    step();
    check("midrst_no_residual1", 64'(pix_valid), 64'd0);
    step();
    check("midrst_no_residual2", 64'(pix_valid), 64'd0);
    start_row(26'h600, 6, 1'b1, 1'b1);
    wait_done(40);
    check_reads("restart", 26'h600, 6);
    check("restart_xfer", 64'(xfer_rel.size()), 64'd6);
    check("restart_sb_empty", 64'(sb.size()), 64'd0);

    step(); step();
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
